cpu1_loader: RTL and testbench

CPU1_LOADER -- requirements
Module: cpu1_loader

---
 rtl/cpu1_loader_if.sv | 22 ++
 rtl/cpu1_loader.sv | 146 ++++++++++++++
 tb/tb_cpu1_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu1_loader_if.sv
// Byte-receive and instruction-fetch bus between the loader and its neighbours
// (UART receiver on the rx side, CPU on the rom side).
interface cpu1_loader_if;
  logic        in_rx_valid;
  logic [7:0]  in_rx_data;
  logic [7:0]  in_rom_addr;
  logic [15:0] out_rom_data;

  modport master (
    output in_rx_valid,
    output in_rx_data,
    output in_rom_addr,
    input  out_rom_data
  );

  modport slave (
    input  in_rx_valid,
    input  in_rx_data,
    input  in_rom_addr,
    output out_rom_data
  );
endinterface

// File: rtl/cpu1_loader.sv
// Serial boot loader: receives framed instruction images into a 256x16 RAM and
// holds the attached CPU in reset until a frame has been received and verified.
module cpu1_loader #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  cpu1_loader_if.slave bus,
  output logic         out_cpu_rst,
  output logic         out_busy,
  output logic         out_err,
  output logic [8:0]   out_words
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_CSUM, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        run_en;
  logic        rx;
  logic        in_frame;
  logic        timeout_hit;
  logic        we;
  logic [7:0]  len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  waddr_q, waddr_d;
  logic [7:0]  csum_q, csum_d;
  logic [8:0]  words_q, words_d;
  logic [8:0]  total;
  logic [15:0] idle_q, idle_d;
  logic        err_q, err_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [15:0] mem [256];
  logic [15:0] rdata_q;

  // Reset assertion is immediate; release is retimed so the FSM never sees a
  // partially released reset.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) sync_q <= 2'b00;
    else           sync_q <= {sync_q[0], 1'b1};
  end

  assign run_en      = sync_q[1];
  assign rx          = run_en & bus.in_rx_valid;
  assign in_frame    = state_q inside {S_LEN, S_HI, S_LO, S_CSUM};
  assign timeout_hit = run_en && in_frame && !bus.in_rx_valid && (idle_q == TIMEOUT - 16'd1);
  assign total       = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      hi_q      <= '0;
      waddr_q   <= '0;
      csum_q    <= '0;
      words_q   <= '0;
      idle_q    <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      waddr_q   <= waddr_d;
      csum_q    <= csum_d;
      words_q   <= words_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    waddr_d = waddr_q;
    csum_d  = csum_q;
    words_d = words_q;
    err_d   = err_q;
    idle_d  = (in_frame && !bus.in_rx_valid) ? idle_q + 16'd1 : 16'd0;
    if (timeout_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else if (rx) begin
      case (state_q)
        S_IDLE, S_RUN: begin
          if (bus.in_rx_data == 8'hA5) begin
            state_d = S_LEN;
            err_d   = 1'b0;
            words_d = '0;
          end
        end
        S_LEN: begin
          len_d   = bus.in_rx_data;
          csum_d  = bus.in_rx_data;
          waddr_d = '0;
          state_d = S_HI;
        end
        S_HI: begin
          hi_d    = bus.in_rx_data;
          csum_d  = csum_q ^ bus.in_rx_data;
          state_d = S_LO;
        end
        S_LO: begin
          csum_d  = csum_q ^ bus.in_rx_data;
          waddr_d = waddr_q + 8'd1;
          words_d = words_q + 9'd1;
          state_d = (words_q + 9'd1 == total) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          if (bus.in_rx_data == csum_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // CPU reset drops only once RUN has been held across an edge, so the final
  // RAM write is always visible before the first fetch; it rises with the sync.
  always_comb begin
    we        = rx && (state_q == S_LO);
    out_busy  = in_frame;
    cpu_rst_d = (state_q != S_RUN) || (state_d != S_RUN);
  end

  always_ff @(posedge in_clk) begin
    if (we) mem[waddr_q] <= {hi_q, bus.in_rx_data};
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) rdata_q <= '0;
    else           rdata_q <= mem[bus.in_rom_addr];
  end

  assign bus.out_rom_data = rdata_q;
  assign out_cpu_rst      = cpu_rst_q;
  assign out_err          = err_q;
  assign out_words        = words_q;

endmodule

// File: tb/tb_cpu1_loader.sv
// Directed bench for cpu1_loader: a frame-level reference model tracks the
// expected outputs cycle by cycle, backed by hand-computed literal checks.
module tb_cpu1_loader;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       out_cpu_rst, out_busy, out_err;
  logic [8:0] out_words;

  cpu1_loader_if bus ();

  cpu1_loader #(.TIMEOUT(16'(TMO))) dut (
    .in_clk     (clk),
    .in_rst_n   (rst_n),
    .bus        (bus),
    .out_cpu_rst(out_cpu_rst),
    .out_busy   (out_busy),
    .out_err    (out_err),
    .out_words  (out_words)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Frame-level reference model: position within the frame, running XOR,
  // silent-cycle count, and a shadow of the RAM with per-word known flags.
  logic [15:0] mmem [256];
  bit          mknown [256];
  bit          m_in_frame, m_run, m_err, prev_run, active;
  int          m_idx, m_n, m_words, silent, sync_cnt;
  logic [7:0]  m_x, m_hi, b;
  logic [15:0] exp_rom;
  bit          rom_known;
  bit          exp_cpu_rst;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_frame = 0; m_run = 0; m_err = 0; m_words = 0; silent = 0;
      sync_cnt = 0; exp_cpu_rst = 1; exp_rom = 16'h0000; rom_known = 1;
    end else begin
      active = (sync_cnt >= 2);
      if (sync_cnt < 2) sync_cnt++;
      exp_rom   = mmem[bus.in_rom_addr];
      rom_known = mknown[bus.in_rom_addr];
      prev_run  = m_run;
      if (active) begin
        if (bus.in_rx_valid) begin
          silent = 0;
          b = bus.in_rx_data;
          if (!m_in_frame) begin
            if (b == 8'hA5) begin
              m_in_frame = 1; m_idx = 0; m_err = 0; m_words = 0; m_run = 0;
            end
          end else if (m_idx == 0) begin
            m_n = (b == 8'h00) ? 256 : int'(b);
            m_x = b;
            m_idx = 1;
          end else if (m_idx <= 2 * m_n) begin
            m_x = m_x ^ b;
            if (m_idx % 2 == 1) m_hi = b;
            else begin
              mmem[m_words % 256]   = {m_hi, b};
              mknown[m_words % 256] = 1;
              m_words++;
            end
            m_idx++;
          end else begin
            m_in_frame = 0;
            if (b == m_x) m_run = 1;
            else          m_err = 1;
          end
        end else if (m_in_frame) begin
          silent++;
          if (silent == TMO) begin
            m_in_frame = 0;
            m_err = 1;
          end
        end
      end
      exp_cpu_rst = !(m_run && prev_run);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(out_busy), 32'(m_in_frame));
      check("err", 32'(out_err), 32'(m_err));
      check("words", 32'(out_words), 32'(m_words));
      check("cpu_rst", 32'(out_cpu_rst), 32'(exp_cpu_rst));
      if (rom_known) check("rom_data", 32'(bus.out_rom_data), 32'(exp_rom));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    bus.in_rx_valid = 1'b1;
    bus.in_rx_data  = v;
    @(negedge clk);
    bus.in_rx_valid = 1'b0;
  endtask

  task automatic read_rom(input string nm, input logic [7:0] a, input logic [15:0] exp);
    bus.in_rom_addr = a;
    cyc(1);
    check(nm, 32'(bus.out_rom_data), 32'(exp));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_rst"}, 32'(out_cpu_rst), 32'd1);
    check({tag, "_busy"}, 32'(out_busy), 32'd0);
    check({tag, "_err"}, 32'(out_err), 32'd0);
    check({tag, "_words"}, 32'(out_words), 32'd0);
    check({tag, "_rom"}, 32'(bus.out_rom_data), 32'd0);
  endtask

  logic [7:0] x;
  logic [7:0] f1 [7];

  initial begin
    bus.in_rx_valid = 1'b0;
    bus.in_rx_data  = 8'h00;
    bus.in_rom_addr = 8'h00;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("por");
    chk_en = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    // Good frame: XOR of 02,12,34,56,78 is 0A.
    f1 = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
    for (int i = 0; i < 7; i++) send_byte(f1[i]);
    check("f1_cpu_rst_hold", 32'(out_cpu_rst), 32'd1);
    check("f1_words", 32'(out_words), 32'd2);
    check("f1_err", 32'(out_err), 32'd0);
    check("f1_busy", 32'(out_busy), 32'd0);
    cyc(1);
    check("f1_cpu_rst_run", 32'(out_cpu_rst), 32'd0);
    read_rom("f1_mem1", 8'd1, 16'h5678);
    read_rom("f1_mem0", 8'd0, 16'h1234);

    // Sync while running re-asserts CPU reset, then the same frame with a bad checksum.
    send_byte(8'hA5);
    check("resync_cpu_rst", 32'(out_cpu_rst), 32'd1);
    check("resync_busy", 32'(out_busy), 32'd1);
    for (int i = 1; i < 6; i++) send_byte(f1[i]);
    send_byte(8'hFF);
    check("bad_err", 32'(out_err), 32'd1);
    check("bad_busy", 32'(out_busy), 32'd0);
    check("bad_words", 32'(out_words), 32'd2);
    cyc(2);
    check("bad_cpu_rst", 32'(out_cpu_rst), 32'd1);
    read_rom("bad_mem0", 8'd0, 16'h1234);

    // Inter-byte timeout inside a frame.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hAB);
    cyc(TMO - 1);
    check("tmo_busy_before", 32'(out_busy), 32'd1);
    check("tmo_err_before", 32'(out_err), 32'd0);
    cyc(1);
    check("tmo_busy", 32'(out_busy), 32'd0);
    check("tmo_err", 32'(out_err), 32'd1);

    // Length 0 means 256 words: word i = {i, i^5A}.
    send_byte(8'hA5);
    send_byte(8'h00);
    x = 8'h00;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(8'(i) ^ 8'h5A);
      x = x ^ 8'(i) ^ (8'(i) ^ 8'h5A);
    end
    send_byte(x);
    check("big_words", 32'(out_words), 32'h100);
    check("big_err", 32'(out_err), 32'd0);
    read_rom("big_mem255", 8'd255, 16'hFFA5);
    read_rom("big_mem0", 8'd0, 16'h005A);
    check("big_cpu_rst", 32'(out_cpu_rst), 32'd0);

    // Reset between the high and low byte of the second word.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hC3);
    send_byte(8'h3C);
    send_byte(8'hD4);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid");
    @(negedge clk);
    send_byte(8'h55);
    cyc(1);
    rst_n = 1'b1;
    send_byte(8'h77);
    cyc(3);
    read_rom("mid_mem0", 8'd0, 16'hC33C);
    read_rom("mid_mem1", 8'd1, 16'h015B);
    read_rom("mid_mem2", 8'd2, 16'h0258);
    check("mid_busy", 32'(out_busy), 32'd0);

    // One-word frame after reset: 01^BE^EF = 50.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h50);
    check("one_words", 32'(out_words), 32'd1);
    cyc(1);
    check("one_cpu_rst", 32'(out_cpu_rst), 32'd0);
    read_rom("one_mem0", 8'd0, 16'hBEEF);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
